// File: rtl/status_pkg.sv
// status_pkg: shared FSM encoding and payload layout for the status receiver
package status_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, WRITE} state_e;
  localparam int SEQ_BITS = 6;
  localparam int ST0_BITS = 2;
  localparam int ST1_BITS = 8;
  localparam int ST2_BITS = 8;
  localparam int ST3_BITS = 8;
  localparam int ST1_LSB = ST0_BITS;
  localparam int ST2_LSB = ST1_LSB + ST1_BITS;
  localparam int ST3_LSB = ST2_LSB + ST2_BITS;
  localparam int MAX_PAYLOAD_BYTES = 4;
endpackage

// File: rtl/status_receiver_mem.sv
// status_receiver_mem: read-first RAM, one write port, one registered read port
// Ports: mclk/rst clock and async reset; we/waddr/wdata write; re/raddr read
// strobe and address; rdata/rvalid registered result one cycle after re.
// STATUS_RECEIVER_UPDATED_EN adds per-entry updated bits returned on rupd.
module status_receiver_mem #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rvalid
`ifdef STATUS_RECEIVER_UPDATED_EN
  , output logic               rupd
`endif
);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;
  always_ff @(posedge mclk)
    if (we) mem[waddr] <= wdata;
  // the array is read before this edge's write lands, giving read-first
  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
    rvalid_d = re;
  end
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
`ifdef STATUS_RECEIVER_UPDATED_EN
  logic [2**ADDR_BITS-1:0] upd_q, upd_d;
  logic rupd_q, rupd_d;
  // the write is applied after the read clear so a colliding write keeps the bit
  always_comb begin
    upd_d = upd_q;
    if (re) upd_d[raddr] = 1'b0;
    if (we) upd_d[waddr] = 1'b1;
    rupd_d = re ? upd_q[raddr] : rupd_q;
  end
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      upd_q <= '0;
      rupd_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
      rupd_q <= rupd_d;
    end
  assign rupd = rupd_q;
`endif
endmodule

// File: rtl/status_receiver.sv
// status_receiver: root of the status tree; grants, deserializes and stores status packets
// Ports: mclk/rst clock and async reset; status_ad/status_rq byte stream and
// request; status_start one-cycle grant; rd_en/rd_addr/rd_data/rd_valid
// register-file read; pkt_stb/pkt_addr commit pulse and last address;
// err_clr/err_long sticky overlength flag.
// STATUS_RECEIVER_UPDATED_EN adds rd_updated, the per-entry updated bit.
module status_receiver #(
  parameter int STATUS_ADDR_BITS = 8,
  parameter int PAYLOAD_BITS = 26,
  parameter int MAX_PAYLOAD_BYTES = status_pkg::MAX_PAYLOAD_BYTES
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic [7:0]                  status_ad,
  input  logic                        status_rq,
  output logic                        status_start,
  input  logic                        rd_en,
  input  logic [STATUS_ADDR_BITS-1:0] rd_addr,
  output logic [31:0]                 rd_data,
  output logic                        rd_valid,
  output logic                        pkt_stb,
  output logic [STATUS_ADDR_BITS-1:0] pkt_addr,
  input  logic                        err_clr,
  output logic                        err_long
`ifdef STATUS_RECEIVER_UPDATED_EN
  , output logic                      rd_updated
`endif
);
  import status_pkg::*;
  localparam int BCNT_W = $clog2(MAX_PAYLOAD_BYTES);
  localparam int DATA_BITS = SEQ_BITS + PAYLOAD_BITS;
  state_e state_q, state_d;
  logic [STATUS_ADDR_BITS-1:0] addr_q, addr_d, pkt_addr_q, pkt_addr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [SEQ_BITS-1:0] seq_q, seq_d;
  logic [PAYLOAD_BITS-1:0] st_q, st_d;
  logic err_q, err_d;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    bcnt_d = bcnt_q;
    seq_d = seq_q;
    st_d = st_q;
    err_d = err_q;
    pkt_addr_d = (state_q == WRITE) ? addr_q : pkt_addr_q;
    case (state_q)
      IDLE: if (status_rq) begin
        state_d = RECV;
        addr_d = STATUS_ADDR_BITS'(status_ad);
        bcnt_d = '0;
        seq_d = '0;
        st_d = '0;
      end
      RECV: begin
        bcnt_d = bcnt_q + 1'b1;
        case (bcnt_q)
          BCNT_W'(0): begin
            seq_d = status_ad[ST0_BITS +: SEQ_BITS];
            st_d[0 +: ST0_BITS] = status_ad[0 +: ST0_BITS];
          end
          BCNT_W'(1): st_d[ST1_LSB +: ST1_BITS] = status_ad[0 +: ST1_BITS];
          BCNT_W'(2): st_d[ST2_LSB +: ST2_BITS] = status_ad[0 +: ST2_BITS];
          default: st_d[ST3_LSB +: ST3_BITS] = status_ad[0 +: ST3_BITS];
        endcase
        if (!status_rq) state_d = WRITE;
        else if (bcnt_q == BCNT_W'(MAX_PAYLOAD_BYTES - 1)) begin
          state_d = DRAIN;
          err_d = 1'b1;
        end
      end
      DRAIN: if (!status_rq) state_d = WRITE;
      default: state_d = IDLE;
    endcase
    if (err_clr) err_d = 1'b0;
  end
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      pkt_addr_q <= '0;
      bcnt_q <= '0;
      seq_q <= '0;
      st_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pkt_addr_q <= pkt_addr_d;
      bcnt_q <= bcnt_d;
      seq_q <= seq_d;
      st_q <= st_d;
      err_q <= err_d;
    end
  // grant is combinational so the address byte shares its cycle; masked while in reset
  assign status_start = (state_q == IDLE) && status_rq && !rst;
  assign pkt_stb = state_q == WRITE;
  assign pkt_addr = pkt_addr_q;
  assign err_long = err_q;
  status_receiver_mem #(
    .ADDR_BITS(STATUS_ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_mem (
    .mclk(mclk),
    .rst(rst),
    .we(pkt_stb),
    .waddr(addr_q),
    .wdata({seq_q, st_q}),
    .re(rd_en),
    .raddr(rd_addr),
    .rdata(rd_data),
    .rvalid(rd_valid)
`ifdef STATUS_RECEIVER_UPDATED_EN
    , .rupd(rd_updated)
`endif
  );
endmodule

// File: tb/tb_status_receiver.sv
// tb_status_receiver: directed self-checking bench for status_receiver
module tb_status_receiver;
  logic mclk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] status_ad = '0;
  logic status_rq = 1'b0;
  logic status_start;
  logic rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic rd_valid;
  logic pkt_stb;
  logic [7:0] pkt_addr;
  logic err_clr = 1'b0;
  logic err_long;
`ifdef STATUS_RECEIVER_UPDATED_EN
  logic rd_updated;
`endif
  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_start = 0, n_stb = 0, last_start = 0, last_stb = 0;
  int s0, b0;

  status_receiver dut (
    .mclk(mclk),
    .rst(rst),
    .status_ad(status_ad),
    .status_rq(status_rq),
    .status_start(status_start),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .pkt_stb(pkt_stb),
    .pkt_addr(pkt_addr),
    .err_clr(err_clr),
    .err_long(err_long)
`ifdef STATUS_RECEIVER_UPDATED_EN
    , .rd_updated(rd_updated)
`endif
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;
  always @(negedge mclk) begin
    if (status_start) begin
      n_start++;
      last_start = cyc;
    end
    if (pkt_stb) begin
      n_stb++;
      last_stb = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic grant();
    logic got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge mclk);
      if (status_start) got = 1'b1;
      step();
    end
    chk("grant", 32'(got), 1);
  endtask

  task automatic send(input logic [7:0] a, input logic [47:0] b, input int n, input int clr_at);
    status_rq = 1'b1;
    status_ad = a;
    grant();
    for (int i = 0; i < n; i++) begin
      status_ad = b[8*i +: 8];
      status_rq = (i != n - 1);
      err_clr = (i == clr_at);
      step();
    end
    status_rq = 1'b0;
    status_ad = '0;
    err_clr = 1'b0;
    chk("stb", 32'(pkt_stb), 1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic u);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk(tag, rd_data, exp);
`ifdef STATUS_RECEIVER_UPDATED_EN
    chk({tag, "_upd"}, 32'(rd_updated), 32'(u));
`endif
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_start"}, 32'(status_start), 0);
    chk({tag, "_stb"}, 32'(pkt_stb), 0);
    chk({tag, "_rvalid"}, 32'(rd_valid), 0);
    chk({tag, "_err"}, 32'(err_long), 0);
    chk({tag, "_paddr"}, 32'(pkt_addr), 0);
    chk({tag, "_rdata"}, rd_data, 0);
  endtask

  initial begin
    status_rq = 1'b1;
    status_ad = 8'h24;
    repeat (3) @(posedge mclk);
    #1;
    rst_chk("rst");
    status_rq = 1'b0;
    rst = 1'b0;
    step();

    s0 = n_start;
    b0 = n_stb;
    send(8'h24, 48'h0000_5634_12A6, 4, -1);
    step();
    chk("pkt_addr24", 32'(pkt_addr), 32'h24);
    chk("start_once", n_start - s0, 1);
    chk("stb_once", n_stb - b0, 1);
    rd_chk("rd24", 8'h24, 32'hA558D04A, 1'b1);
    step();
    chk("rd_hold", rd_data, 32'hA558D04A);
    chk("rd_valid_lo", 32'(rd_valid), 0);

    send(8'h10, 48'h07, 1, -1);
    step();
    rd_chk("rd10", 8'h10, 32'h04000003, 1'b1);
    chk("err_short", 32'(err_long), 0);

    b0 = n_stb;
    send(8'h30, 48'h6655_4433_2211, 6, -1);
    chk("err_set", 32'(err_long), 1);
    step();
    chk("stb_ovl", n_stb - b0, 1);
    rd_chk("rd30", 8'h30, 32'h1110CC89, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'(err_long), 0);
    send(8'h31, 48'h6655_4433_2211, 6, 3);
    chk("err_prio", 32'(err_long), 0);
    step();

    send(8'h40, 48'h0000_0403_0201, 4, -1);
    send(8'h41, 48'h0000_8000_FFFC, 4, -1);
    chk("b2b_gap", last_start - last_stb, 1);
    step();
    rd_chk("rd40", 8'h40, 32'h00100C09, 1'b1);
    rd_chk("rd41", 8'h41, 32'hFE0003FC, 1'b1);

    send(8'h05, 48'h5A, 1, -1);
    step();
    rd_chk("rd05a", 8'h05, 32'h58000002, 1'b1);
    status_rq = 1'b1;
    status_ad = 8'h05;
    grant();
    status_ad = 8'hFF;
    step();
    status_ad = 8'hFF;
    step();
    rst = 1'b1;
    #1;
    rst_chk("midrst");
    step();
    status_rq = 1'b0;
    rst = 1'b0;
    step();
    rd_chk("rd05_kept", 8'h05, 32'h58000002, 1'b0);
    send(8'h05, 48'hAB09, 2, -1);
    step();
    rd_chk("rd05b", 8'h05, 32'h080002AD, 1'b1);

    send(8'h24, 48'h03, 1, -1);
    rd_chk("coll_old", 8'h24, 32'hA558D04A, 1'b0);
    rd_chk("coll_new", 8'h24, 32'h00000003, 1'b1);
    rd_chk("coll_again", 8'h24, 32'h00000003, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
